// File: rtl/mv_result_collector_if.sv
// Handshake bundle between the result collector, the motion estimator and the bitstream packer.
// master: the collector's view; slave: the surrounding estimator/consumer environment.
interface mv_result_collector_if #(
  parameter int unsigned BLK_W = 8
);
  logic               frame_start;
  logic [BLK_W-1:0]   num_blocks;
  logic               est_start;
  logic               est_completed;
  logic [7:0]         est_best_dist;
  logic [3:0]         est_motion_x;
  logic [3:0]         est_motion_y;
  logic               out_valid;
  logic               out_ready;
  logic [BLK_W+15:0]  out_data;
  logic               out_intra;
  logic               busy;
  logic               frame_done;

  modport master (
    input  frame_start, num_blocks, est_completed, est_best_dist, est_motion_x, est_motion_y,
    input  out_ready,
    output est_start, out_valid, out_data, out_intra, busy, frame_done
  );

  modport slave (
    output frame_start, num_blocks, est_completed, est_best_dist, est_motion_x, est_motion_y,
    output out_ready,
    input  est_start, out_valid, out_data, out_intra, busy, frame_done
  );
endinterface

// File: rtl/mv_result_collector.sv
// Per-frame sequencer for the full-search motion estimator plus a first-word-fall-through
// result FIFO. Optional intra flagging is enabled by defining SAD_THRESH_EN.
module mv_result_collector #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BLK_W  = 8,
  parameter logic [7:0]  THRESH = 8'd64
) (
  input logic                   clk_i,
  input logic                   rst_i,
  mv_result_collector_if.master bus
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = AW + 1;
  localparam int unsigned EntW = BLK_W + 16;
  localparam logic [CntW-1:0]  DepthCnt = CntW'(DEPTH);
  localparam logic [BLK_W-1:0] IdxOne   = BLK_W'(1);

  typedef enum logic [2:0] {StIdle, StLaunch, StRun, StRelease, StDone} state_e;

  state_e           state_q;
  logic             est_start_q;
  logic             busy_q;
  logic             frame_done_q;
  logic [BLK_W-1:0] blk_idx_q;
  logic [BLK_W-1:0] nb_q;

  logic [EntW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  count_d;
  logic             push;
  logic             pop;
  logic             out_valid;
  logic [EntW-1:0]  entry;

  assign entry     = {blk_idx_q, bus.est_best_dist, bus.est_motion_x, bus.est_motion_y};
  assign push      = (state_q == StRun) && bus.est_completed;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && bus.out_ready;

  // Sequencer: outputs are registered so they line up with the state they belong to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      est_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      blk_idx_q    <= '0;
      nb_q         <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.frame_start) begin
            busy_q    <= 1'b1;
            blk_idx_q <= '0;
            if (bus.num_blocks != '0) begin
              nb_q    <= bus.num_blocks;
              state_q <= StLaunch;
            end else begin
              frame_done_q <= 1'b1;
              state_q      <= StDone;
            end
          end
        end
        StLaunch: begin
          // One search in flight at a time, so a free slot here guarantees the push fits.
          if (count_q < DepthCnt) begin
            est_start_q <= 1'b1;
            state_q     <= StRun;
          end
        end
        StRun: begin
          if (bus.est_completed) begin
            est_start_q <= 1'b0;
            state_q     <= StRelease;
          end
        end
        StRelease: begin
          if (blk_idx_q == nb_q - IdxOne) begin
            frame_done_q <= 1'b1;
            state_q      <= StDone;
          end else begin
            blk_idx_q <= blk_idx_q + IdxOne;
            state_q   <= StLaunch;
          end
        end
        StDone: begin
          frame_done_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          est_start_q  <= 1'b0;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= entry;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  assign bus.est_start  = est_start_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_valid ? mem_q[rd_ptr_q] : '0;

`ifdef SAD_THRESH_EN
  logic [DEPTH-1:0] intra_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      intra_q <= '0;
    end else if (push) begin
      intra_q[wr_ptr_q] <= (bus.est_best_dist > THRESH);
    end
  end

  assign bus.out_intra = out_valid & intra_q[rd_ptr_q];
`else
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign bus.out_intra = 1'b0;
`endif

  push_fits_a: assert property (@(posedge clk_i) disable iff (rst_i) push |-> (count_q < DepthCnt));
  count_bound_a: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= DepthCnt);
  est_start_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                est_start_q == (state_q == StRun));

endmodule

// File: tb/tb_mv_result_collector.sv
// Bench for mv_result_collector: estimator model plus a queue-based reference of expected
// FIFO entries (k-th search of a frame is block k); directed and random frames.
module tb_mv_result_collector;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BLK_W = 8;

  typedef struct {
    logic [BLK_W+15:0] data;
    logic              intra;
  } exp_t;

  logic clk;
  logic rst;

  mv_result_collector_if #(.BLK_W(BLK_W)) bus ();

  mv_result_collector #(
    .DEPTH (DEPTH),
    .BLK_W (BLK_W),
    .THRESH(8'd64)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  exp_t       exp_q[$];
  logic [7:0] force_q[$];
  logic       intra_log[$];
  logic [BLK_W-1:0] serve_idx = '0;
  int fixed_lat = 0;
  int lat_cur   = 1;
  int est_cnt   = 0;
  int est_rises = 0;
  int pops      = 0;
  int fd_pulses = 0;
  logic est_prev = 1'b0;
  logic [7:0] m_d;
  logic [3:0] m_mx;
  logic [3:0] m_my;
  exp_t m_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic intra_of(input logic [7:0] d);
`ifdef SAD_THRESH_EN
    return d > 8'd64;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Estimator: counts cycles while est_start is high, done after lat_cur cycles.
  assign bus.est_completed = bus.est_start && (est_cnt >= lat_cur);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      est_cnt           <= 0;
      bus.est_best_dist <= '0;
      bus.est_motion_x  <= '0;
      bus.est_motion_y  <= '0;
    end else if (!bus.est_start) begin
      est_cnt <= 0;
    end else begin
      if (est_cnt == 0) begin
        m_d  = (force_q.size() != 0) ? force_q.pop_front() : 8'($urandom);
        m_mx = 4'($urandom);
        m_my = 4'($urandom);
        bus.est_best_dist <= m_d;
        bus.est_motion_x  <= m_mx;
        bus.est_motion_y  <= m_my;
        lat_cur <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
        exp_q.push_back('{data: {serve_idx, m_d, m_mx, m_my}, intra: intra_of(m_d)});
        serve_idx = serve_idx + 1'b1;
      end
      est_cnt <= est_cnt + 1;
    end
  end

  // Consumer side: every accepted head is compared against the reference queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.est_start && !est_prev) est_rises++;
      if (bus.frame_done) fd_pulses++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL pop_unexpected: observed 0x%0h expected no entry", bus.out_data);
        end else begin
          m_e = exp_q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(m_e.data));
          chk("out_intra", 64'(bus.out_intra), 64'(m_e.intra));
          intra_log.push_back(bus.out_intra);
          pops++;
        end
      end
    end
    est_prev = bus.est_start;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int nb);
    serve_idx       = '0;
    bus.num_blocks  = BLK_W'(nb);
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (bus.busy && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(bus.busy), 64'd0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid && n < 50) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic reset_counts();
    est_rises = 0;
    pops      = 0;
    fd_pulses = 0;
    intra_log.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int nb;
    rst             = 1'b1;
    bus.frame_start = 1'b0;
    bus.num_blocks  = '0;
    bus.out_ready   = 1'b0;
    tick(3);
    chk("rst_est_start", 64'(bus.est_start), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_intra", 64'(bus.out_intra), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
    rst = 1'b0;
    tick(1);

    // Three blocks, fixed latency 10; a frame_start mid-frame must be ignored.
    reset_counts();
    fixed_lat     = 10;
    bus.out_ready = 1'b1;
    start_frame(3);
    tick(20);
    bus.num_blocks  = BLK_W'(5);
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
    wait_idle(200, "t1_idle");
    tick(2);
    chk("t1_searches", 64'(est_rises), 64'd3);
    chk("t1_pops", 64'(pops), 64'd3);
    chk("t1_frame_done_pulses", 64'(fd_pulses), 64'd1);
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: six blocks into a four-deep FIFO with the consumer stalled.
    reset_counts();
    fixed_lat     = 0;
    bus.out_ready = 1'b0;
    start_frame(6);
    tick(120);
    chk("t2_parked_searches", 64'(est_rises), 64'd4);
    chk("t2_parked_est_start", 64'(bus.est_start), 64'd0);
    chk("t2_parked_busy", 64'(bus.busy), 64'd1);
    chk("t2_parked_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    wait_idle(300, "t2_idle");
    drain("t2_drain");
    chk("t2_searches", 64'(est_rises), 64'd6);
    chk("t2_pops", 64'(pops), 64'd6);
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Simultaneous push and pop at two entries: occupancy must stay at two.
    reset_counts();
    bus.out_ready = 1'b0;
    start_frame(5);
    n = 0;
    while (est_rises < 3 && n < 200) begin
      tick(1);
      n++;
    end
    n = 0;
    while (!bus.est_completed && n < 50) begin
      tick(1);
      n++;
    end
    chk("t3_pre_completed", 64'(bus.est_completed), 64'd1);
    chk("t3_pre_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    wait_idle(300, "t3_idle_no_ready");
    chk("t3_pops_before_drain", 64'(pops), 64'd1);
    chk("t3_searches", 64'(est_rises), 64'd5);
    drain("t3_drain");
    chk("t3_pops", 64'(pops), 64'd5);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of block 1, then a fresh frame restarts at block 0.
    reset_counts();
    fixed_lat     = 10;
    bus.out_ready = 1'b0;
    start_frame(3);
    n = 0;
    while (est_rises < 2 && n < 100) begin
      tick(1);
      n++;
    end
    tick(2);
    chk("t4_in_run", 64'(bus.est_start), 64'd1);
    chk("t4_valid_before", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("t4_rst_est_start", 64'(bus.est_start), 64'd0);
    chk("t4_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_rst_busy", 64'(bus.busy), 64'd0);
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    fixed_lat = 0;
    tick(1);
    reset_counts();
    bus.out_ready = 1'b1;
    start_frame(2);
    wait_idle(200, "t4_idle");
    drain("t4_drain");
    chk("t4_pops", 64'(pops), 64'd2);
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // Empty frame: straight to DONE, and frame_start held into DONE is ignored.
    reset_counts();
    serve_idx       = '0;
    bus.num_blocks  = '0;
    bus.frame_start = 1'b1;
    tick(1);
    chk("t5_frame_done", 64'(bus.frame_done), 64'd1);
    chk("t5_busy", 64'(bus.busy), 64'd1);
    chk("t5_est_start", 64'(bus.est_start), 64'd0);
    bus.num_blocks = BLK_W'(3);
    tick(1);
    bus.frame_start = 1'b0;
    chk("t5_frame_done_end", 64'(bus.frame_done), 64'd0);
    chk("t5_busy_end", 64'(bus.busy), 64'd0);
    tick(30);
    chk("t5_no_search", 64'(est_rises), 64'd0);
    chk("t5_pulses", 64'(fd_pulses), 64'd1);
    chk("t5_still_idle", 64'(bus.busy), 64'd0);

    // Intra threshold boundaries.
    reset_counts();
    force_q.push_back(8'd64);
    force_q.push_back(8'd65);
    force_q.push_back(8'd255);
    bus.out_ready = 1'b1;
    start_frame(3);
    wait_idle(200, "t6_idle");
    drain("t6_drain");
    chk("t6_count", 64'(intra_log.size()), 64'd3);
    if (intra_log.size() == 3) begin
      chk("t6_intra_64", 64'(intra_log[0]), 64'd0);
`ifdef SAD_THRESH_EN
      chk("t6_intra_65", 64'(intra_log[1]), 64'd1);
      chk("t6_intra_255", 64'(intra_log[2]), 64'd1);
`else
      chk("t6_intra_65", 64'(intra_log[1]), 64'd0);
      chk("t6_intra_255", 64'(intra_log[2]), 64'd0);
`endif
    end

    // Random frames with a randomly stalling consumer.
    for (int f = 0; f < 4; f++) begin
      reset_counts();
      nb = int'($urandom_range(1, 8));
      start_frame(nb);
      n = 0;
      while (bus.busy && n < 3000) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        tick(1);
        n++;
      end
      chk("rnd_idle", 64'(bus.busy), 64'd0);
      drain("rnd_drain");
      chk("rnd_searches", 64'(est_rises), 64'(nb));
      chk("rnd_pops", 64'(pops), 64'(nb));
      chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
